// File: rtl/run_controller.sv
// Launch/monitor controller for a single-clock processor: pulses cpu_start, masks a stale
// halt for one guard cycle, then counts run cycles and strobes until halt or timeout.
module run_controller #(
    parameter int unsigned START_WIDTH    = 1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        run_req,
    input  logic        cpu_halt,
    input  logic        cpu_reg_write,
    input  logic        cpu_mem_write,
    input  logic        cpu_branch,
    input  logic [15:0] cpu_inst_count,
    output logic        cpu_start,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic [15:0] cycle_count,
    output logic [15:0] reg_write_count,
    output logic [15:0] mem_write_count,
    output logic [15:0] branch_count,
    output logic [15:0] final_inst_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GUARD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] START_LAST = 4'(START_WIDTH - 1);

    state_t      state_q, state_d;
    logic [3:0]  start_cnt_q, start_cnt_d;
    logic        cpu_start_q, cpu_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timed_out_q, timed_out_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [15:0] reg_write_count_q, reg_write_count_d;
    logic [15:0] mem_write_count_q, mem_write_count_d;
    logic [15:0] branch_count_q, branch_count_d;
    logic [15:0] final_inst_count_q, final_inst_count_d;
    logic        timeout_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Widened so that TIMEOUT_CYCLES = 16'hFFFF is reachable without wrap.
    assign timeout_hit = ({1'b0, cycle_count_q} + 17'd1) == {1'b0, TIMEOUT_CYCLES};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d            = state_q;
        start_cnt_d        = start_cnt_q;
        timed_out_d        = timed_out_q;
        cycle_count_d      = cycle_count_q;
        reg_write_count_d  = reg_write_count_q;
        mem_write_count_d  = mem_write_count_q;
        branch_count_d     = branch_count_q;
        final_inst_count_d = final_inst_count_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (run_req) begin
                    state_d            = S_START;
                    start_cnt_d        = 4'd0;
                    timed_out_d        = 1'b0;
                    cycle_count_d      = 16'd0;
                    reg_write_count_d  = 16'd0;
                    mem_write_count_d  = 16'd0;
                    branch_count_d     = 16'd0;
                    final_inst_count_d = 16'd0;
                end
            end
            S_START: begin
                if (start_cnt_q == START_LAST) begin
                    state_d     = S_GUARD;
                    start_cnt_d = 4'd0;
                end else begin
                    start_cnt_d = start_cnt_q + 4'd1;
                end
            end
            S_GUARD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (cpu_reg_write) reg_write_count_d = sat_inc(reg_write_count_q);
                if (cpu_mem_write) mem_write_count_d = sat_inc(mem_write_count_q);
                if (cpu_branch)    branch_count_d    = sat_inc(branch_count_q);
                // Halt is checked first so a halt on the timeout cycle is not reported as a timeout.
                if (cpu_halt) begin
                    state_d            = S_DONE;
                    timed_out_d        = 1'b0;
                    final_inst_count_d = cpu_inst_count;
                end else if (timeout_hit) begin
                    state_d            = S_DONE;
                    timed_out_d        = 1'b1;
                    final_inst_count_d = cpu_inst_count;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flag outputs are decoded from the next state so they leave the block registered.
        cpu_start_d = (state_d == S_START);
        busy_d      = (state_d == S_START) || (state_d == S_GUARD) || (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q            <= S_IDLE;
            start_cnt_q        <= 4'd0;
            cpu_start_q        <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            timed_out_q        <= 1'b0;
            cycle_count_q      <= 16'd0;
            reg_write_count_q  <= 16'd0;
            mem_write_count_q  <= 16'd0;
            branch_count_q     <= 16'd0;
            final_inst_count_q <= 16'd0;
        end else begin
            state_q            <= state_d;
            start_cnt_q        <= start_cnt_d;
            cpu_start_q        <= cpu_start_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            timed_out_q        <= timed_out_d;
            cycle_count_q      <= cycle_count_d;
            reg_write_count_q  <= reg_write_count_d;
            mem_write_count_q  <= mem_write_count_d;
            branch_count_q     <= branch_count_d;
            final_inst_count_q <= final_inst_count_d;
        end
    end

    assign cpu_start        = cpu_start_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign timed_out        = timed_out_q;
    assign cycle_count      = cycle_count_q;
    assign reg_write_count  = reg_write_count_q;
    assign mem_write_count  = mem_write_count_q;
    assign branch_count     = branch_count_q;
    assign final_inst_count = final_inst_count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: two configurations driven by shared stimulus, each checked
// every cycle against an age-based run model, plus targeted scenario checks.
module tb_run_controller;

    localparam int SW_A = 1;
    localparam int TO_A = 1000;
    localparam int SW_B = 3;
    localparam int TO_B = 10;

    logic        CLK = 1'b0;
    logic        reset;
    logic        run_req;
    logic        cpu_halt;
    logic        cpu_reg_write;
    logic        cpu_mem_write;
    logic        cpu_branch;
    logic [15:0] cpu_inst_count;

    logic        a_cpu_start, a_busy, a_done, a_timed_out;
    logic [15:0] a_cycle_count, a_reg_write_count, a_mem_write_count, a_branch_count, a_final_inst_count;
    logic        b_cpu_start, b_busy, b_done, b_timed_out;
    logic [15:0] b_cycle_count, b_reg_write_count, b_mem_write_count, b_branch_count, b_final_inst_count;

    always #5 CLK = ~CLK;

    run_controller #(.START_WIDTH(SW_A), .TIMEOUT_CYCLES(16'(TO_A))) dut_a (
        .CLK(CLK), .reset(reset), .run_req(run_req), .cpu_halt(cpu_halt),
        .cpu_reg_write(cpu_reg_write), .cpu_mem_write(cpu_mem_write), .cpu_branch(cpu_branch),
        .cpu_inst_count(cpu_inst_count),
        .cpu_start(a_cpu_start), .busy(a_busy), .done(a_done), .timed_out(a_timed_out),
        .cycle_count(a_cycle_count), .reg_write_count(a_reg_write_count),
        .mem_write_count(a_mem_write_count), .branch_count(a_branch_count),
        .final_inst_count(a_final_inst_count)
    );

    run_controller #(.START_WIDTH(SW_B), .TIMEOUT_CYCLES(16'(TO_B))) dut_b (
        .CLK(CLK), .reset(reset), .run_req(run_req), .cpu_halt(cpu_halt),
        .cpu_reg_write(cpu_reg_write), .cpu_mem_write(cpu_mem_write), .cpu_branch(cpu_branch),
        .cpu_inst_count(cpu_inst_count),
        .cpu_start(b_cpu_start), .busy(b_busy), .done(b_done), .timed_out(b_timed_out),
        .cycle_count(b_cycle_count), .reg_write_count(b_reg_write_count),
        .mem_write_count(b_mem_write_count), .branch_count(b_branch_count),
        .final_inst_count(b_final_inst_count)
    );

    // A run is tracked by its age: ages 1..sw are start cycles, sw+1 the guard, beyond that running.
    typedef struct {
        bit          active;
        int          age;
        bit          done_f;
        bit          to_f;
        logic [15:0] cyc;
        logic [15:0] rw;
        logic [15:0] mw;
        logic [15:0] br;
        logic [15:0] fin;
    } mdl_t;

    mdl_t ma, mb;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   starts_a = 0;
    int   starts_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic mdl_t model_next(input mdl_t m, input int sw, input int to);
        mdl_t n = m;
        if (reset) begin
            n = '{default: '0};
        end else if (m.active) begin
            if (m.age > sw + 1) begin
                n.cyc = sat16(m.cyc);
                if (cpu_reg_write) n.rw = sat16(m.rw);
                if (cpu_mem_write) n.mw = sat16(m.mw);
                if (cpu_branch)    n.br = sat16(m.br);
                if (cpu_halt || int'(n.cyc) == to) begin
                    n.active = 1'b0;
                    n.done_f = 1'b1;
                    n.to_f   = !cpu_halt;
                    n.fin    = cpu_inst_count;
                end
            end
            n.age = m.age + 1;
        end else if (run_req) begin
            n        = '{default: '0};
            n.active = 1'b1;
            n.age    = 1;
        end
        return n;
    endfunction

    task automatic check_dut(input string p, input mdl_t m, input int sw,
                             input logic cs, input logic bz, input logic dn, input logic tmo,
                             input logic [15:0] cc, input logic [15:0] rw, input logic [15:0] mw,
                             input logic [15:0] br, input logic [15:0] fin);
        check({p, ".cpu_start"},        cs,  (m.active && m.age <= sw));
        check({p, ".busy"},             bz,  m.active);
        check({p, ".done"},             dn,  m.done_f);
        check({p, ".timed_out"},        tmo, m.to_f);
        check({p, ".cycle_count"},      cc,  m.cyc);
        check({p, ".reg_write_count"},  rw,  m.rw);
        check({p, ".mem_write_count"},  mw,  m.mw);
        check({p, ".branch_count"},     br,  m.br);
        check({p, ".final_inst_count"}, fin, m.fin);
    endtask

    task automatic step();
        @(posedge CLK);
        ma = model_next(ma, SW_A, TO_A);
        mb = model_next(mb, SW_B, TO_B);
        #1;
        check_dut("a", ma, SW_A, a_cpu_start, a_busy, a_done, a_timed_out, a_cycle_count,
                  a_reg_write_count, a_mem_write_count, a_branch_count, a_final_inst_count);
        check_dut("b", mb, SW_B, b_cpu_start, b_busy, b_done, b_timed_out, b_cycle_count,
                  b_reg_write_count, b_mem_write_count, b_branch_count, b_final_inst_count);
        if (a_cpu_start) starts_a++;
        if (b_cpu_start) starts_b++;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        run_req = 1'b0;
        step();
        reset    = 1'b0;
        starts_a = 0;
        starts_b = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        ma = '{default: '0};
        mb = '{default: '0};
        reset = 1'b1; run_req = 1'b0; cpu_halt = 1'b0;
        cpu_reg_write = 1'b0; cpu_mem_write = 1'b0; cpu_branch = 1'b0;
        cpu_inst_count = 16'd0;
        step();
        step();
        check("reset_busy_a", a_busy, 1'b0);
        check("reset_cycles_b", b_cycle_count, 16'd0);
        reset = 1'b0;

        // Basic run, accepted on the first edge after reset
        starts_a = 0;
        run_req = 1'b1; step(); run_req = 1'b0;
        step(); step();
        repeat (20) step();
        cpu_halt = 1'b1; cpu_inst_count = 16'd42; step(); cpu_halt = 1'b0;
        check("basic_done", a_done, 1'b1);
        check("basic_cycles", a_cycle_count, 16'd21);
        check("basic_final_inst", a_final_inst_count, 16'd42);
        check("basic_timed_out", a_timed_out, 1'b0);
        check("basic_start_width", starts_a, 1);

        // Strobe tallies: strobes high in the accept, START and GUARD cycles are ignored
        run_req = 1'b1; cpu_reg_write = 1'b1; cpu_mem_write = 1'b1; cpu_branch = 1'b1;
        step(); run_req = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            cpu_reg_write = (i < 5); cpu_mem_write = (i < 3); cpu_branch = (i < 2);
            step();
        end
        cpu_reg_write = 1'b0; cpu_mem_write = 1'b0; cpu_branch = 1'b0;
        cpu_halt = 1'b1; step(); cpu_halt = 1'b0;
        check("strobe_reg", a_reg_write_count, 16'd5);
        check("strobe_mem", a_mem_write_count, 16'd3);
        check("strobe_branch", a_branch_count, 16'd2);
        check("strobe_cycles", a_cycle_count, 16'd11);

        // Timeout on the TIMEOUT_CYCLES=10 instance
        do_reset();
        run_req = 1'b1; step(); run_req = 1'b0;
        n = 0;
        while (!b_done && n < 40) begin step(); n++; end
        check("timeout_reached", b_done, 1'b1);
        check("timeout_flag", b_timed_out, 1'b1);
        check("timeout_cycles", b_cycle_count, 16'd10);
        repeat (3) step();
        check("timeout_no_restart", starts_b, SW_B);
        check("timeout_done_held", b_done, 1'b1);

        // Stale halt through START and GUARD, then halt/timeout collision
        do_reset();
        cpu_halt = 1'b1; run_req = 1'b1; step(); run_req = 1'b0;
        n = 0;
        while (!b_done && n < 20) begin step(); n++; end
        check("stale_halt_cycles_b", b_cycle_count, 16'd1);
        check("stale_halt_cycles_a", a_cycle_count, 16'd1);
        check("stale_halt_timed_out", b_timed_out, 1'b0);
        cpu_halt = 1'b0;
        run_req = 1'b1; step(); run_req = 1'b0;
        n = 0;
        while (b_cycle_count != 16'd9 && n < 30) begin step(); n++; end
        cpu_halt = 1'b1; cpu_inst_count = 16'h1234; step(); cpu_halt = 1'b0;
        check("collision_done", b_done, 1'b1);
        check("collision_cycles", b_cycle_count, 16'd10);
        check("collision_timed_out", b_timed_out, 1'b0);
        check("collision_final", b_final_inst_count, 16'h1234);

        // Reset in the middle of a run, then a clean run
        do_reset();
        run_req = 1'b1; step(); run_req = 1'b0;
        n = 0;
        while (a_cycle_count != 16'd7 && n < 30) begin step(); n++; end
        check("midrun_reached", a_cycle_count, 16'd7);
        reset = 1'b1; step(); reset = 1'b0;
        check("midrun_busy", a_busy, 1'b0);
        check("midrun_cycles", a_cycle_count, 16'd0);
        check("midrun_start", b_cpu_start, 1'b0);
        run_req = 1'b1; step(); run_req = 1'b0;
        step(); step();
        repeat (4) step();
        cpu_halt = 1'b1; cpu_inst_count = 16'd7; step(); cpu_halt = 1'b0;
        check("midrun_clean_cycles", a_cycle_count, 16'd5);
        check("midrun_clean_final", a_final_inst_count, 16'd7);

        // Second request during RUN is ignored (START_WIDTH=3)
        do_reset();
        run_req = 1'b1; step(); run_req = 1'b0;
        n = 0;
        while (!(b_busy && b_cycle_count == 16'd3) && n < 20) begin step(); n++; end
        run_req = 1'b1; step(); run_req = 1'b0;
        n = 0;
        while (!b_done && n < 30) begin step(); n++; end
        check("ignore_req_starts", starts_b, SW_B);
        check("ignore_req_cycles", b_cycle_count, 16'd10);
        step();
        check("ignore_req_stays_done", b_busy, 1'b0);

        // run_req held high relaunches from DONE every time
        do_reset();
        run_req = 1'b1; cpu_halt = 1'b1;
        repeat (30) step();
        check("relaunch_starts_a", starts_a, 8);
        run_req = 1'b0; cpu_halt = 1'b0;

        // Randomized traffic, checked every cycle against the model
        do_reset();
        repeat (1500) begin
            reset          = ($urandom_range(0, 99) == 0);
            run_req        = ($urandom_range(0, 7) == 0);
            cpu_halt       = ($urandom_range(0, 15) == 0);
            cpu_reg_write  = 1'($urandom);
            cpu_mem_write  = 1'($urandom);
            cpu_branch     = 1'($urandom);
            cpu_inst_count = 16'($urandom);
            step();
        end

        reset = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
